// File: rtl/axi_slave_mem.sv
// AXI4 slave with a MEM_DEPTH x 32-bit memory; independent read/write FSMs.
// Define AXI_SLV_ERR_EN to enable SLVERR responses (range, WLAST, WRAP length).
module axi_slave_mem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        ARESETn,
  input  logic        AWVALID,
  input  logic [4:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic        AWLOCK,
  input  logic [3:0]  AWCACHE,
  input  logic [2:0]  AWPROT,
  input  logic [3:0]  AWQOS,
  input  logic [3:0]  AWREGION,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  output logic        WREADY,
  output logic        BVALID,
  output logic [4:0]  BID,
  output logic [1:0]  BRESP,
  input  logic        BREADY,
  input  logic        ARVALID,
  input  logic [4:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARLOCK,
  input  logic [3:0]  ARCACHE,
  input  logic [2:0]  ARPROT,
  input  logic [3:0]  ARQOS,
  input  logic [3:0]  ARREGION,
  output logic        ARREADY,
  output logic        RVALID,
  output logic [4:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  input  logic        READY
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [MEM_DEPTH];

  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  // WRAP keeps the low bits inside a (LEN+1)<<SIZE byte window
  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [1:0]  s;
    logic [31:0] step, mask;
    s    = (size > 3'd2) ? 2'd2 : size[1:0];
    step = 32'd1 << s;
    mask = (({24'd0, len} + 32'd1) << s) - 32'd1;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  w_state_t    w_state;
  logic [4:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;

  r_state_t    r_state;
  logic [31:0] r_addr, r_next;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_bad;

  logic w_fire, w_last, w_oor, w_bad, aw_bad;
  logic ar_bad, ar_oor, rn_oor;
  logic unused_ign;

  assign w_fire = WVALID && WREADY;
  assign w_last = (w_beat == w_len);
  assign r_next = next_addr(r_addr, r_len, r_size, r_burst);

`ifdef AXI_SLV_ERR_EN
  assign aw_bad = (AWBURST == 2'b10) &&
                  !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign ar_bad = (ARBURST == 2'b10) &&
                  !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign w_oor  = (w_addr[31:AW+2] != '0);
  assign w_bad  = w_oor || (WLAST != w_last);
  assign ar_oor = (ARADDR[31:AW+2] != '0);
  assign rn_oor = (r_next[31:AW+2] != '0);
`else
  logic unused_rng;
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
  assign w_oor  = 1'b0;
  assign w_bad  = 1'b0;
  assign ar_oor = 1'b0;
  assign rn_oor = 1'b0;
  assign unused_rng = ^{WLAST, w_addr, ARADDR, r_next};
`endif

  assign unused_ign = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
                        ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION};

  // Memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (w_fire && !w_oor)
      for (int b = 0; b < 4; b++)
        if (WSTRB[b]) mem[idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'b00;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_beat  <= '0;
            w_err   <= aw_bad;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= (w_err || w_bad) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
              w_err  <= w_err || w_bad;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= 2'b00;
      RID     <= '0;
      RDATA   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_bad   <= 1'b0;
    end else if (r_state == R_IDLE) begin
      ARREADY <= 1'b1;
      if (ARVALID && ARREADY) begin
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_beat  <= '0;
        r_bad   <= ar_bad;
        ARREADY <= 1'b0;
        RVALID  <= 1'b1;
        RID     <= ARID;
        RLAST   <= (ARLEN == 8'd0);
        RDATA   <= ar_oor ? '0 : mem[idx(ARADDR)];
        RRESP   <= (ar_oor || ar_bad) ? 2'b10 : 2'b00;
        r_state <= R_DATA;
      end
    end else if (READY) begin
      if (r_beat == r_len) begin
        RVALID  <= 1'b0;
        RLAST   <= 1'b0;
        ARREADY <= 1'b1;
        r_state <= R_IDLE;
      end else begin
        r_beat <= r_beat + 8'd1;
        r_addr <= r_next;
        RLAST  <= ((r_beat + 8'd1) == r_len);
        RDATA  <= rn_oor ? '0 : mem[idx(r_next)];
        RRESP  <= (rn_oor || r_bad) ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have port clk, in, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port ARESETn, in, 1, asynchronous active-low reset.
REQ-004 SHALL have ports AWVALID/AWID/AWADDR/AWLEN/AWSIZE/AWBURST, in, 1/5/32/8/3/2, the write-address request.
REQ-005 SHALL have port AWREADY, out, 1, write-address accept.
REQ-006 SHALL have ports WVALID/WDATA/WSTRB/WLAST, in, 1/32/4/1, the write data.
REQ-007 SHALL have port WREADY, out, 1, write-data accept.
REQ-008 SHALL have ports BVALID/BID/BRESP, out, 1/5/2, the write response; BREADY, in, 1.
REQ-009 SHALL have ports ARVALID/ARID/ARADDR/ARLEN/ARSIZE/ARBURST, in, 1/5/32/8/3/2, the read-address request; ARREADY, out, 1.
REQ-010 SHALL have ports RVALID/RID/RDATA/RRESP/RLAST, out, 1/5/32/2/1, the read data; READY, in, 1, the read-data ready.
REQ-011 SHALL have inputs AW/AR LOCK(1), CACHE(4), PROT(3), QOS(4), REGION(4) accepted and ignored.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-013 On AWVALID&&AWREADY the block SHALL capture ID/ADDR/LEN/SIZE/BURST, clear the beat counter and enter W_DATA the next cycle.
REQ-014 Each WVALID&&WREADY SHALL write byte lanes selected by WSTRB into mem[(addr>>2) mod MEM_DEPTH]; lanes with a 0 strobe are unchanged.
REQ-015 Burst termination SHALL be by beat counter: when beat == LEN, go to W_RESP; WLAST does not end the burst.
REQ-016 W_RESP SHALL hold BVALID, BID=captured ID and BRESP stable until BREADY, then return to W_IDLE.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1); on AR handshake it captures request fields and asserts RVALID on the next cycle.
REQ-018 RDATA SHALL be the full word at the current beat address; RID=captured ID; RLAST=1 only when beat == ARLEN.
REQ-019 RDATA/RLAST/RID/RRESP SHALL stay stable while RVALID&&!READY; the beat advances only on RVALID&&READY; the last beat returns to R_IDLE.
REQ-020 Next address SHALL be: FIXED (00) unchanged; INCR (01) addr + (1<<SIZE); WRAP (10) increment within a (LEN+1)*(1<<SIZE)-byte aligned window; reserved (11) treated as INCR.
REQ-021 SIZE > 2 SHALL be treated as SIZE = 2.
REQ-022 Read and write channels SHALL run independently and concurrently; a read of a word written in the same cycle returns the old contents.
REQ-023 Address 4*MEM_DEPTH and above SHALL alias modulo MEM_DEPTH unless REQ-028 applies.

Reset
REQ-024 ARESETn low SHALL immediately force both FSMs idle and AWREADY=WREADY=BVALID=ARREADY=RVALID=RLAST=0, BRESP=RRESP=2'b00, BID=RID=0, RDATA=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no response; already-written bytes are retained.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 AWREADY and ARREADY SHALL go to 1 on the first clock edge after ARESETn deasserts.

Configuration
REQ-028 With AXI_SLV_ERR_EN defined, the block SHALL respond SLVERR (2'b10) for:
- any beat address >= 4*MEM_DEPTH: the write is suppressed and RDATA=0 on reads;
- WLAST mismatched with the final beat;
- WRAP with LEN not in {1,3,7,15}.
The error status is sticky per burst for BRESP and per beat for RRESP.
REQ-029 Without AXI_SLV_ERR_EN, BRESP and RRESP SHALL always be 2'b00 and addresses alias per REQ-023.

Verification
REQ-030 INCR write: AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=F -> BRESP=00, BID=AWID; then INCR read of the same burst -> 0xA0..0xA3 with RLAST on beat 3.
REQ-031 WRAP read: ARADDR=0x38, LEN=3, SIZE=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
REQ-032 Strobe: word holds 0x11223344; write 0xAABBCCDD with WSTRB=0101 -> reads back 0x11BB33DD.
REQ-033 Backpressure: READY low for 3 cycles mid-burst -> RDATA/RLAST stable, no beat lost; BREADY held low 5 cycles -> BVALID held.
REQ-034 ARESETn pulsed during beat 2 of an 8-beat write -> outputs take reset values, no BVALID, AWREADY=1 after release, beats 0-1 retained.
REQ-035 With AXI_SLV_ERR_EN: write to 4*MEM_DEPTH -> BRESP=10 and memory unchanged; without it: BRESP=00 and word 0 is overwritten.
